// File: rtl/generic_fifo_drain_pkg.sv
// Shared types and constants for the generic_fifo read-side drain controller.
// Used by generic_fifo_drain and generic_skid_buffer_2.
package generic_fifo_drain_pkg;

  typedef enum logic [1:0] {
    DRAIN_EMPTY = 2'd0,
    DRAIN_ONE   = 2'd1,
    DRAIN_TWO   = 2'd2
  } drain_state_t;

  localparam int DRAIN_BUF_ENTRIES = 2;
  localparam int DRAIN_COUNT_WIDTH = 32;

  function automatic logic [1:0] drain_occ(input drain_state_t s);
    case (s)
      DRAIN_ONE: return 2'd1;
      DRAIN_TWO: return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/generic_skid_buffer_2.sv
// Two-entry output buffer: EMPTY/ONE/TWO FSM, head/tail pointers,
// and a registered head word so the output never comes from a mux.
module generic_skid_buffer_2
  import generic_fifo_drain_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output drain_state_t  o_state
);

  drain_state_t r_state;
  drain_state_t w_state_nxt;
  logic [DW-1:0] r_mem [DRAIN_BUF_ENTRIES];
  logic [DW-1:0] r_head;
  logic [DW-1:0] w_head_nxt;
  logic          r_wr_ptr;
  logic          r_rd_ptr;

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    unique case (r_state)
      DRAIN_EMPTY: begin
        if (i_push) begin
          w_state_nxt = DRAIN_ONE;
          w_head_nxt  = i_data;
        end
      end
      DRAIN_ONE: begin
        if (i_push & ~i_pop)      w_state_nxt = DRAIN_TWO;
        else if (~i_push & i_pop) w_state_nxt = DRAIN_EMPTY;
        if (i_push & i_pop)       w_head_nxt  = i_data;
      end
      DRAIN_TWO: begin
        // The second entry becomes head; a same-cycle push refills the freed slot.
        if (i_pop) begin
          if (~i_push) w_state_nxt = DRAIN_ONE;
          w_head_nxt = r_mem[~r_rd_ptr];
        end
      end
      default: w_state_nxt = DRAIN_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= DRAIN_EMPTY;
      r_head   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int i = 0; i < DRAIN_BUF_ENTRIES; i++) r_mem[i] <= '0;
    end else if (clear) begin
      r_state  <= DRAIN_EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
    end
  end

  assign o_valid = (r_state != DRAIN_EMPTY);
  assign o_data  = r_head;
  assign o_state = r_state;

endmodule

// File: rtl/generic_fifo_drain.sv
// Read-side controller for generic_fifo: credit-based pops into a 2-entry buffer.
// Optional macro DRAIN_COUNT_EN adds the drain_count accepted-word counter.
module generic_fifo_drain
  import generic_fifo_drain_pkg::*;
#(
  parameter int DRAIN_DATA_WIDTH   = 32,
  parameter int DRAIN_READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset_poweron,
  input  logic                        clear,
  input  logic                        fifo_empty,
  output logic                        fifo_read,
  input  logic [DRAIN_DATA_WIDTH-1:0] fifo_read_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DRAIN_DATA_WIDTH-1:0] out_data,
  output logic                        busy
`ifdef DRAIN_COUNT_EN
  ,
  output logic [DRAIN_COUNT_WIDTH-1:0] drain_count
`endif
);

  localparam logic LAT1 = (DRAIN_READ_LATENCY == 1);

  drain_state_t w_state;
  logic         w_pop;
  logic         w_capture;
  logic         r_infl;
  logic [1:0]   w_occ;
  logic [2:0]   w_credit;

  assign w_pop    = out_valid & out_ready;
  assign w_occ    = drain_occ(w_state);
  assign w_credit = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_pop};

  // Reset gates the pop strobe so it drops immediately, not at the next edge.
  assign fifo_read = ~reset_poweron & ~fifo_empty & ~clear
                   & (w_credit < 3'd2);

  assign w_capture = LAT1 ? (r_infl & ~clear) : fifo_read;
  assign busy      = out_valid | r_infl;

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) r_infl <= 1'b0;
    else               r_infl <= LAT1 & fifo_read;
  end

  generic_skid_buffer_2 #(
    .DW (DRAIN_DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (reset_poweron),
    .clear   (clear),
    .i_push  (w_capture),
    .i_data  (fifo_read_data),
    .i_pop   (w_pop),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_state (w_state)
  );

`ifdef DRAIN_COUNT_EN
  logic [DRAIN_COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) r_count <= '0;
    else if (clear)    r_count <= '0;
    else if (w_pop)    r_count <= r_count + DRAIN_COUNT_WIDTH'(1);
  end

  assign drain_count = r_count;
`endif

endmodule
